// File: rtl/disaggregator.sv
// Wide-to-narrow width converter: unpacks one FIFO word into
// FETCH_WIDTH elements, LSB slice first, one element per cycle.
module disaggregator #(
  parameter int DATA_WIDTH  = 11,
  parameter int FETCH_WIDTH = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  output logic                              busy,
  output logic [COUNT_WIDTH-1:0]            words_done
);

  localparam int IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] holding;
  logic                              valid;
  logic [IDX_W-1:0]                  idx;
  logic                              last;

  assign last         = (idx == IDX_W'(FETCH_WIDTH - 1));
  assign receiver_enq = valid && receiver_full_n;
  assign busy         = valid;

  // rst_n gate keeps the pop quiet while reset is held
  assign sender_deq = rst_n && sender_empty_n &&
                      (!valid || (last && receiver_enq));

  always_comb begin
    receiver_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (idx == IDX_W'(i)) begin
        receiver_data = holding[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holding    <= '0;
      valid      <= 1'b0;
      idx        <= '0;
      words_done <= '0;
    end else begin
      if (sender_deq) begin
        holding <= sender_data;
        valid   <= 1'b1;
        idx     <= '0;
      end else if (receiver_enq) begin
        if (last) begin
          valid <= 1'b0;
          idx   <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
      if (receiver_enq && last) begin
        words_done <= words_done + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Self-checking bench for disaggregator: vector table, directed
// corner sequences and a random-stall scoreboard run.
module tb_disaggregator;

  localparam int DW = 11;
  localparam int FW = 2;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [FW*DW-1:0] sender_data = '0;
  logic           sender_empty_n = 1'b0;
  logic           sender_deq;
  logic [DW-1:0]  receiver_data;
  logic           receiver_full_n = 1'b1;
  logic           receiver_enq;
  logic           busy;
  logic [CW-1:0]  words_done;

  disaggregator #(
    .DATA_WIDTH (DW),
    .FETCH_WIDTH(FW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sender_data    (sender_data),
    .sender_empty_n (sender_empty_n),
    .sender_deq     (sender_deq),
    .receiver_data  (receiver_data),
    .receiver_full_n(receiver_full_n),
    .receiver_enq   (receiver_enq),
    .busy           (busy),
    .words_done     (words_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW*DW-1:0] word;
    logic [DW-1:0]    e0;
    logic [DW-1:0]    e1;
  } vec_t;

  vec_t tbl[6];

  logic [FW*DW-1:0] src[$];
  logic [DW-1:0]    exp_q[$];

  int checks = 0;
  int failures = 0;
  int rdy_pct = 100;
  int avail_pct = 0;
  bit do_pop = 0;
  bit bad_deq = 0;
  int exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [FW*DW-1:0] w,
                      input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    src.push_back(w);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", 32'(n < max_cyc), 32'd1);
  endtask

  // upstream FWFT FIFO model and downstream ready generator
  always @(posedge clk) begin
    #1;
    if (do_pop) begin
      if (src.size() != 0) src.delete(0);
      do_pop = 0;
    end
    receiver_full_n = (int'($urandom_range(0, 99)) < rdy_pct);
    sender_empty_n  = (src.size() != 0) &&
                      (int'($urandom_range(0, 99)) < avail_pct);
    sender_data     = (src.size() != 0) ? src[0] : '0;
  end

  // scoreboard: compare every fired element against the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (sender_deq && !sender_empty_n) bad_deq = 1;
      do_pop = sender_deq;
      if (receiver_enq) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_elem", 32'(receiver_data), 32'hFFFF_FFFF);
        end else begin
          chk("elem_data", 32'(receiver_data), 32'(exp_q.pop_front()));
        end
      end
    end else begin
      do_pop = 0;
    end
  end

  initial begin
    logic [FW*DW-1:0] w;

    tbl[0] = '{{11'd5, 11'd3},       11'd3,     11'd5};
    tbl[1] = '{{11'd2, 11'd1},       11'd1,     11'd2};
    tbl[2] = '{{11'h7FF, 11'h000},   11'h000,   11'h7FF};
    tbl[3] = '{{11'h000, 11'h7FF},   11'h7FF,   11'h000};
    tbl[4] = '{{11'h400, 11'h001},   11'h001,   11'h400};
    tbl[5] = '{{11'h2AA, 11'h555},   11'h555,   11'h2AA};

    // reset held with a word available upstream
    send({11'd5, 11'd3}, 11'd3, 11'd5);
    avail_pct = 100;
    repeat (2) begin
      @(negedge clk);
      chk("rst_deq", 32'(sender_deq), 32'd0);
      chk("rst_enq", 32'(receiver_enq), 32'd0);
      chk("rst_data", 32'(receiver_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(words_done), 32'd0);
    end
    src.delete();
    exp_q.delete();
    avail_pct = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // empty upstream for 10 cycles
    begin
      bit any;
      any = 0;
      repeat (10) begin
        @(negedge clk);
        if (sender_deq || receiver_enq || busy) any = 1;
      end
      chk("empty_activity", 32'(any), 32'd0);
      chk("empty_done", 32'(words_done), 32'd0);
    end

    // single word {5,3}: deq, then 3, then 5
    send({11'd5, 11'd3}, 11'd3, 11'd5);
    avail_pct = 100;
    @(negedge clk);
    chk("single_deq", 32'(sender_deq), 32'd1);
    chk("single_enq0", 32'(receiver_enq), 32'd0);
    @(negedge clk);
    chk("single_e0_enq", 32'(receiver_enq), 32'd1);
    chk("single_e0_data", 32'(receiver_data), 32'd3);
    chk("single_e0_deq", 32'(sender_deq), 32'd0);
    @(negedge clk);
    chk("single_e1_enq", 32'(receiver_enq), 32'd1);
    chk("single_e1_data", 32'(receiver_data), 32'd5);
    @(negedge clk);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_done", 32'(words_done), 32'd1);
    exp_done = 1;

    // table vectors, one word at a time
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].word, tbl[i].e0, tbl[i].e1);
      drain(20);
      exp_done++;
      chk("tbl_done", 32'(words_done), 32'(exp_done));
    end

    // back-to-back: 1..6 on consecutive cycles
    send({11'd2, 11'd1}, 11'd1, 11'd2);
    send({11'd4, 11'd3}, 11'd3, 11'd4);
    send({11'd6, 11'd5}, 11'd5, 11'd6);
    @(negedge clk);
    chk("b2b_first_deq", 32'(sender_deq), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("b2b_enq", 32'(receiver_enq), 32'd1);
      chk("b2b_data", 32'(receiver_data), 32'(c));
      chk("b2b_deq", 32'(sender_deq), 32'(c == 2 || c == 4));
    end
    @(negedge clk);
    exp_done += 3;
    chk("b2b_done", 32'(words_done), 32'(exp_done));
    chk("b2b_busy", 32'(busy), 32'd0);

    // backpressure while idx=1
    send({11'd20, 11'd10}, 11'd10, 11'd20);
    @(negedge clk);
    chk("bp_deq", 32'(sender_deq), 32'd1);
    @(negedge clk);
    chk("bp_e0", 32'(receiver_data), 32'd10);
    rdy_pct = 0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(receiver_data), 32'd20);
      chk("bp_hold_enq", 32'(receiver_enq), 32'd0);
      chk("bp_hold_deq", 32'(sender_deq), 32'd0);
      chk("bp_hold_busy", 32'(busy), 32'd1);
    end
    rdy_pct = 100;
    @(negedge clk);
    chk("bp_release_enq", 32'(receiver_enq), 32'd1);
    drain(10);
    exp_done++;
    chk("bp_done", 32'(words_done), 32'(exp_done));

    // random stalls over 200 words
    rdy_pct = 60;
    avail_pct = 60;
    for (int i = 0; i < 200; i++) begin
      w = {11'($urandom), 11'($urandom)};
      send(w, w[DW-1:0], w[2*DW-1:DW]);
    end
    drain(5000);
    exp_done += 200;
    chk("rand_done", 32'(words_done), 32'(exp_done));
    rdy_pct = 100;
    avail_pct = 100;

    // reset after slice 0 of {9,7}; 9 must never appear
    src.push_back({11'd9, 11'd7});
    exp_q.push_back(11'd7);
    @(negedge clk);
    chk("mrst_deq", 32'(sender_deq), 32'd1);
    @(negedge clk);
    chk("mrst_e0", 32'(receiver_data), 32'd7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_data", 32'(receiver_data), 32'd0);
    chk("mrst_enq", 32'(receiver_enq), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_deq0", 32'(sender_deq), 32'd0);
    chk("mrst_cnt", 32'(words_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send({11'd13, 11'd12}, 11'd12, 11'd13);
    drain(20);
    chk("mrst_after_done", 32'(words_done), 32'd1);

    chk("deq_while_empty", 32'(bad_deq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/disaggregator.md
DISAGGREGATOR -- requirements
Module: disaggregator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, the width of one narrow output element.
REQ-002 SHALL have parameter FETCH_WIDTH, default 2, the number of narrow elements per wide input word; legal range is 1..16.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, the width of the output word counter.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 sender_data  input  FETCH_WIDTH*DATA_WIDTH  wide word from the upstream first-word-fall-through FIFO; valid whenever sender_empty_n=1.
REQ-007 sender_empty_n  input  1  upstream holds at least one word.
REQ-008 sender_deq  output  1  pops the upstream word this cycle.
REQ-009 receiver_data  output  DATA_WIDTH  current narrow element.
REQ-010 receiver_full_n  input  1  downstream can accept an element this cycle.
REQ-011 receiver_enq  output  1  pushes receiver_data downstream this cycle.
REQ-012 busy  output  1  a wide word is held and not fully emitted.
REQ-013 words_done  output  COUNT_WIDTH  count of wide words fully emitted since reset.

Function
REQ-014 SHALL hold one wide word in a holding register with a valid bit and a slice index idx in the range 0..FETCH_WIDTH-1.
REQ-015 receiver_data SHALL equal holding[idx*DATA_WIDTH +: DATA_WIDTH], so emission order is LSB slice first, the exact inverse of the aggregator packing.
REQ-016 receiver_enq SHALL be combinational and equal valid && receiver_full_n.
REQ-017 last SHALL be defined as idx==FETCH_WIDTH-1; an element fires when receiver_enq=1.
REQ-018 sender_deq SHALL be combinational and equal sender_empty_n && (!valid || (last && receiver_enq)).
REQ-019 sender_deq SHALL never assert while sender_empty_n=0.
REQ-020 On sender_deq, SHALL load sender_data into the holding register, set valid=1 and set idx=0.
REQ-021 On a fire with !last, SHALL increment idx by 1; the holding register is unchanged.
REQ-022 On a fire with last and no simultaneous deq, SHALL clear valid and set idx=0.
REQ-023 On a fire with last and a simultaneous deq, reload SHALL take priority, so valid stays 1 and idx=0; consecutive words SHALL stream with no bubble.
REQ-024 On every fire with last, words_done SHALL increment by 1, wrapping modulo 2^COUNT_WIDTH.
REQ-025 Latency from the deq cycle to the first receiver_enq SHALL be 1 cycle, given receiver_full_n=1.
REQ-026 Sustained throughput SHALL be one element per cycle.
REQ-027 While receiver_full_n=0, SHALL hold idx, the holding register and receiver_data stable, with receiver_enq=0 and no deq while valid.
REQ-028 busy SHALL equal valid.
REQ-029 With FETCH_WIDTH=1, every fire SHALL be last and the block SHALL reduce to a one-entry pipeline register.
REQ-030 No element SHALL be dropped or duplicated under any pattern of sender_empty_n and receiver_full_n.

Reset
REQ-031 While rst_n=0, SHALL asynchronously clear valid, idx, words_done and the holding register to 0.
REQ-032 While rst_n=0, sender_deq=0, receiver_enq=0, receiver_data=0 and busy=0.
REQ-033 A reset asserted mid-word SHALL discard the remaining slices; no element from that word SHALL be emitted after release.
REQ-034 The first deq after reset release SHALL occur no earlier than the first rising edge with rst_n=1 and sender_empty_n=1.

Verification
REQ-035 Single word: FETCH_WIDTH=2, DATA_WIDTH=11, sender_data={11'd5,11'd3}, full_n=1 -> deq for 1 cycle; then enq with data 3, then enq with data 5; words_done=1; busy=0 afterwards.
REQ-036 Back-to-back: three words {2,1},{4,3},{6,5} always available -> receiver sees 1,2,3,4,5,6 on 6 consecutive cycles; deq asserts on the same cycle as each last element (except the first deq); words_done=3.
REQ-037 Backpressure: full_n=0 for 4 cycles while idx=1 -> receiver_data stays at the slice 1 value, enq=0 and deq=0; after full_n returns to 1, that element is emitted exactly once.
REQ-038 Empty upstream: sender_empty_n=0 for 10 cycles after reset -> deq=0, enq=0, busy=0, words_done=0.
REQ-039 Random stall: random sender_empty_n and full_n over 200 words from the internal-node data file -> output stream equals input words split LSB-first, and words_done=200.
REQ-040 Mid-word reset: rst_n=0 after slice 0 of {11'd9,11'd7} -> outputs are 0 immediately; after release, 9 is never emitted and the next word starts at idx 0.
